// File: rtl/game_state_ctrl.sv
// Game-flow controller for the runner game: IDLE/RUN/PAUSE/DYING/OVER sequencing,
// life and difficulty-level bookkeeping, and a tick-timed death phase.
module game_state_ctrl #(
  parameter  int LIVES        = 3,
  parameter  int DEATH_HOLD   = 60,
  parameter  int TICKS_PER_LV = 600,
  parameter  int LEVEL_W      = 3,
  localparam int LIFE_W       = $clog2(LIVES + 1),
  localparam int CNT_MAX      = (DEATH_HOLD > TICKS_PER_LV) ? DEATH_HOLD : TICKS_PER_LV,
  localparam int CNT_W        = $clog2(CNT_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_op,
  input  logic               pause_op,
  input  logic               dead,
  input  logic               tick,
  output logic [2:0]         state,
  output logic [LIFE_W-1:0]  lives,
  output logic [LEVEL_W-1:0] level,
  output logic               game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DYING = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]   DIST_LAST  = CNT_W'(TICKS_PER_LV - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(DEATH_HOLD - 1);
  localparam logic [LIFE_W-1:0]  LIVES_INIT = LIFE_W'(LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = '1;

  state_t             r_state,      w_state_nxt;
  logic [LIFE_W-1:0]  r_lives,      w_lives_nxt;
  logic [LEVEL_W-1:0] r_level,      w_level_nxt;
  logic               r_game_over,  w_game_over_nxt;
  logic [CNT_W-1:0]   r_dist,       w_dist_nxt;
  logic [CNT_W-1:0]   r_hold,       w_hold_nxt;
  logic               r_jump_prev;
  logic               r_pause_prev;

  logic w_jmp_rise;
  logic w_pse_rise;

  assign w_jmp_rise = jump_op  & ~r_jump_prev;
  assign w_pse_rise = pause_op & ~r_pause_prev;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order statements appear in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_lives      <= '0;
      r_level      <= '0;
      r_game_over  <= 1'b0;
      r_dist       <= '0;
      r_hold       <= '0;
      r_jump_prev  <= 1'b0;
      r_pause_prev <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lives      <= w_lives_nxt;
      r_level      <= w_level_nxt;
      r_game_over  <= w_game_over_nxt;
      r_dist       <= w_dist_nxt;
      r_hold       <= w_hold_nxt;
      r_jump_prev  <= jump_op;
      r_pause_prev <= pause_op;
    end
  end

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_lives_nxt     = r_lives;
    w_level_nxt     = r_level;
    w_game_over_nxt = 1'b0;
    w_dist_nxt      = r_dist;
    w_hold_nxt      = r_hold;

    case (r_state)
      S_IDLE: begin
        if (w_jmp_rise) begin
          w_state_nxt = S_RUN;
          w_lives_nxt = LIVES_INIT;
          w_level_nxt = '0;
          w_dist_nxt  = '0;
        end
      end

      S_RUN: begin
        // A collision outranks a pause press made in the same cycle.
        if (dead) begin
          w_state_nxt = S_DYING;
          w_lives_nxt = (r_lives == '0) ? '0 : r_lives - 1'b1;
          w_hold_nxt  = '0;
        end else if (w_pse_rise) begin
          w_state_nxt = S_PAUSE;
        end else if (tick) begin
          if (r_dist == DIST_LAST) begin
            w_dist_nxt = '0;
            if (r_level != LEVEL_MAX) w_level_nxt = r_level + 1'b1;
          end else begin
            w_dist_nxt = r_dist + 1'b1;
          end
        end
      end

      S_PAUSE: begin
        if (w_pse_rise) w_state_nxt = S_RUN;
      end

      S_DYING: begin
        if (tick) begin
          if (r_hold == HOLD_LAST) begin
            if (r_lives == '0) begin
              w_state_nxt     = S_OVER;
              w_game_over_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RUN;
              w_dist_nxt  = '0;
            end
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
      end

      S_OVER: begin
        if (w_jmp_rise) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign state     = r_state;
  assign lives     = r_lives;
  assign level     = r_level;
  assign game_over = r_game_over;

endmodule
